// File: rtl/ddr2_local_pkg.sv
// Shared state encoding, default parameter values and helpers for the DDR2 local responder.
package ddr2_local_pkg;

  localparam int unsigned DefMemAw      = 10;
  localparam int unsigned DefInitCycles = 16;
  localparam int unsigned DefRdLatency  = 4;
  localparam int unsigned DefRefPeriod  = 64;
  localparam int unsigned DefRefCycles  = 4;

  // Width of the init/wait/refresh counters.
  localparam int unsigned CntW = 16;

  typedef enum logic [2:0] {
    StInit,
    StIdle,
    StWrite,
    StRdWait,
    StRead,
    StRefresh
  } state_e;

  // A size of zero still moves one beat.
  function automatic logic [3:0] burst_beats(input logic [3:0] size);
    return (size == 4'd0) ? 4'd1 : size;
  endfunction

endpackage

// File: rtl/ddr2_local_mem.sv
// Single-port 32-bit memory with per-byte write enables and a registered read port.
module ddr2_local_mem #(
  parameter int unsigned AW = 10
) (
  input  logic          clk_i,
  input  logic [AW-1:0] addr_i,
  input  logic          we_i,
  input  logic [3:0]    be_i,
  input  logic [31:0]   wdata_i,
  input  logic          re_i,
  output logic [31:0]   rdata_o
);

  logic [31:0] mem_q [2**AW];
  logic [31:0] rdata_q;

  // Array is deliberately not reset so contents survive a reset.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int b = 0; b < 4; b++) begin
        if (be_i[b]) mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
      end
    end
    if (re_i) rdata_q <= mem_q[addr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/ddr2_local_responder.sv
// DDR2 local-interface responder: init delay, write/read bursts into a local memory,
// periodic refresh stalls and a sticky protocol-error flag.
module ddr2_local_responder
  import ddr2_local_pkg::*;
#(
  parameter int unsigned MEM_AW      = DefMemAw,
  parameter int unsigned INIT_CYCLES = DefInitCycles,
  parameter int unsigned RD_LATENCY  = DefRdLatency,
  parameter int unsigned REF_PERIOD  = DefRefPeriod,
  parameter int unsigned REF_CYCLES  = DefRefCycles
) (
  input  logic        ddr2_clk,
  input  logic        sys_rst_n,
  input  logic [25:0] local_address,
  input  logic        local_write_req,
  input  logic        local_read_req,
  input  logic        local_burstbegin,
  input  logic [31:0] local_wdata,
  input  logic [3:0]  local_be,
  input  logic [3:0]  local_size,
  output logic        local_ready,
  output logic [31:0] local_rdata,
  output logic        local_rdata_valid,
  output logic        local_init_done,
  output logic        proto_err
);

  localparam logic [CntW-1:0] InitC  = CntW'(INIT_CYCLES);
  localparam logic [CntW-1:0] RdLatC = CntW'(RD_LATENCY);
  localparam logic [CntW-1:0] RefPC  = CntW'(REF_PERIOD);
  localparam logic [CntW-1:0] RefCyC = CntW'(REF_CYCLES);

  state_e            state_q, state_d;
  logic [MEM_AW-1:0] addr_q, addr_d;
  logic [3:0]        beats_q, beats_d;
  logic [3:0]        beat_q, beat_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [CntW-1:0]   ref_cnt_q, ref_cnt_d;
  logic              proto_err_q, proto_err_d;

  logic              ref_pending, idle_open, accept, last_beat;
  logic [MEM_AW-1:0] mem_addr;
  logic              mem_we, mem_re;
  logic [31:0]       mem_rdata;
  logic              unused_addr_hi;

  assign unused_addr_hi = ^local_address[25:MEM_AW];
  assign ref_pending    = (ref_cnt_q >= RefPC);
  assign idle_open      = (state_q == StIdle) && !ref_pending;
  assign accept         = idle_open && local_burstbegin && (local_write_req || local_read_req);
  assign last_beat      = (beat_q == 4'(beats_q - 4'd1));

  // State and datapath registers.
  always_ff @(posedge ddr2_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q     <= StInit;
      addr_q      <= '0;
      beats_q     <= '0;
      beat_q      <= '0;
      cnt_q       <= '0;
      ref_cnt_q   <= '0;
      proto_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      beats_q     <= beats_d;
      beat_q      <= beat_d;
      cnt_q       <= cnt_d;
      ref_cnt_q   <= ref_cnt_d;
      proto_err_q <= proto_err_d;
    end
  end

  // Next-state and counter logic.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    beats_d     = beats_q;
    beat_d      = beat_q;
    cnt_d       = cnt_q;
    ref_cnt_d   = ref_cnt_q;
    proto_err_d = proto_err_q;

    // Refresh interval saturates at the period and holds until the refresh is taken.
    if (state_q != StInit && state_q != StRefresh && !ref_pending) begin
      ref_cnt_d = ref_cnt_q + CntW'(1);
    end

    unique case (state_q)
      StInit: begin
        cnt_d = cnt_q + CntW'(1);
        if (cnt_q == InitC - CntW'(1)) begin
          state_d = StIdle;
          cnt_d   = '0;
        end
      end
      StIdle: begin
        if (ref_pending) begin
          // The blocking IDLE cycle counts as the first stall cycle.
          state_d = StRefresh;
          cnt_d   = CntW'(1);
        end else if (accept) begin
          addr_d  = local_address[MEM_AW-1:0];
          beats_d = burst_beats(local_size);
          if (local_write_req) begin
            beat_d = 4'd1;
            if (local_read_req) proto_err_d = 1'b1;
            if (burst_beats(local_size) != 4'd1) state_d = StWrite;
          end else begin
            beat_d = 4'd0;
            cnt_d  = '0;
            state_d = (RD_LATENCY == 1) ? StRead : StRdWait;
          end
        end else if (local_write_req || local_read_req) begin
          proto_err_d = 1'b1;
        end
      end
      StWrite: begin
        if (local_write_req) begin
          if (local_burstbegin) proto_err_d = 1'b1;
          if (last_beat) begin
            state_d = StIdle;
            beat_d  = 4'd0;
          end else begin
            beat_d = beat_q + 4'd1;
          end
        end
      end
      StRdWait: begin
        cnt_d = cnt_q + CntW'(1);
        if (cnt_q + CntW'(2) == RdLatC) begin
          state_d = StRead;
          beat_d  = 4'd0;
        end
      end
      StRead: begin
        if (last_beat) begin
          state_d = StIdle;
          beat_d  = 4'd0;
        end else begin
          beat_d = beat_q + 4'd1;
        end
      end
      StRefresh: begin
        cnt_d = cnt_q + CntW'(1);
        if (cnt_q + CntW'(1) >= RefCyC) begin
          state_d   = StIdle;
          cnt_d     = '0;
          ref_cnt_d = '0;
        end
      end
      default: state_d = StInit;
    endcase
  end

  // Outputs and memory port control; reads are issued one cycle ahead of each valid beat.
  always_comb begin
    local_ready       = idle_open || (state_q == StWrite);
    local_init_done   = (state_q != StInit);
    local_rdata_valid = (state_q == StRead);
    local_rdata       = local_rdata_valid ? mem_rdata : 32'h0;
    proto_err         = proto_err_q;
    mem_addr          = addr_q + MEM_AW'(beat_q);
    mem_we            = 1'b0;
    mem_re            = 1'b0;
    unique case (state_q)
      StIdle: begin
        mem_addr = local_address[MEM_AW-1:0];
        mem_we   = accept && local_write_req;
        mem_re   = accept && !local_write_req && (RD_LATENCY == 1);
      end
      StWrite:  mem_we = local_write_req;
      StRdWait: begin
        mem_addr = addr_q;
        mem_re   = (cnt_q + CntW'(2) == RdLatC);
      end
      StRead: begin
        mem_addr = addr_q + MEM_AW'(beat_q) + MEM_AW'(1);
        mem_re   = !last_beat;
      end
      default: ;
    endcase
  end

  ddr2_local_mem #(
    .AW (MEM_AW)
  ) u_mem (
    .clk_i   (ddr2_clk),
    .addr_i  (mem_addr),
    .we_i    (mem_we),
    .be_i    (local_be),
    .wdata_i (local_wdata),
    .re_i    (mem_re),
    .rdata_o (mem_rdata)
  );

endmodule

// File: tb/tb_ddr2_local_responder.sv
// Directed bench for ddr2_local_responder with default parameters.
module tb_ddr2_local_responder;

  localparam int RdLat = 4;

  logic        ddr2_clk = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic [25:0] local_address = '0;
  logic        local_write_req = 1'b0;
  logic        local_read_req = 1'b0;
  logic        local_burstbegin = 1'b0;
  logic [31:0] local_wdata = '0;
  logic [3:0]  local_be = '0;
  logic [3:0]  local_size = '0;
  logic        local_ready;
  logic [31:0] local_rdata;
  logic        local_rdata_valid;
  logic        local_init_done;
  logic        proto_err;

  int vecs = 0;
  int miss = 0;
  logic [31:0] wdat [16];
  logic [31:0] rexp [16];

  always #5 ddr2_clk = ~ddr2_clk;

  ddr2_local_responder dut (
    .ddr2_clk          (ddr2_clk),
    .sys_rst_n         (sys_rst_n),
    .local_address     (local_address),
    .local_write_req   (local_write_req),
    .local_read_req    (local_read_req),
    .local_burstbegin  (local_burstbegin),
    .local_wdata       (local_wdata),
    .local_be          (local_be),
    .local_size        (local_size),
    .local_ready       (local_ready),
    .local_rdata       (local_rdata),
    .local_rdata_valid (local_rdata_valid),
    .local_init_done   (local_init_done),
    .proto_err         (proto_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      miss++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    vecs++;
    assert (obs === exp) else begin
      miss++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic wait_ready(input string tag);
    int n = 0;
    while (local_ready !== 1'b1 && n < 20) begin
      @(negedge ddr2_clk);
      n++;
    end
    if (n >= 20) chk1(tag, local_ready, 1'b1);
  endtask

  task automatic do_init();
    for (int i = 1; i <= 16; i++) begin
      @(negedge ddr2_clk);
      chk1("init_ready", local_ready, i == 16);
      chk1("init_done", local_init_done, i == 16);
    end
  endtask

  task automatic write_burst(input logic [25:0] a, input logic [3:0] sz, input int n,
                             input logic [3:0] be, input int gap_at);
    wait_ready("wr_wait");
    for (int i = 0; i < n; i++) begin
      if (i == gap_at) begin
        local_write_req  = 1'b0;
        local_burstbegin = 1'b0;
        @(negedge ddr2_clk);
      end
      chk1("wr_ready", local_ready, 1'b1);
      local_write_req  = 1'b1;
      local_burstbegin = (i == 0);
      local_address    = a;
      local_size       = sz;
      local_wdata      = wdat[i];
      local_be         = be;
      @(negedge ddr2_clk);
    end
    local_write_req  = 1'b0;
    local_burstbegin = 1'b0;
  endtask

  task automatic read_burst(input logic [25:0] a, input logic [3:0] sz, input int n);
    logic v;
    wait_ready("rd_wait");
    local_read_req   = 1'b1;
    local_burstbegin = 1'b1;
    local_address    = a;
    local_size       = sz;
    @(negedge ddr2_clk);
    local_read_req   = 1'b0;
    local_burstbegin = 1'b0;
    for (int c = 1; c <= RdLat + n; c++) begin
      v = (c >= RdLat) && (c < RdLat + n);
      chk1("rd_valid", local_rdata_valid, v);
      chk("rd_data", local_rdata, v ? rexp[c-RdLat] : 32'h0);
      if (c < RdLat + n) @(negedge ddr2_clk);
    end
  endtask

  initial begin
    int n;
    // Reset state
    repeat (3) @(negedge ddr2_clk);
    chk1("rst_ready", local_ready, 1'b0);
    chk1("rst_valid", local_rdata_valid, 1'b0);
    chk("rst_rdata", local_rdata, 32'h0);
    chk1("rst_init_done", local_init_done, 1'b0);
    chk1("rst_proto_err", proto_err, 1'b0);
    sys_rst_n = 1'b1;
    do_init();

    // Basic 4-beat write then read-back
    for (int i = 0; i < 4; i++) wdat[i] = 32'(i + 1);
    write_burst(26'h10, 4'd4, 4, 4'hF, -1);
    for (int i = 0; i < 4; i++) rexp[i] = 32'(i + 1);
    read_burst(26'h10, 4'd4, 4);

    // Address wrap at the top of memory
    wdat[0] = 32'hA; wdat[1] = 32'hB; wdat[2] = 32'hC; wdat[3] = 32'hD;
    write_burst(26'h3FE, 4'd4, 4, 4'hF, -1);
    rexp[0] = 32'hC; rexp[1] = 32'hD;
    read_burst(26'h0, 4'd2, 2);

    // Byte enables
    wdat[0] = 32'hFFFF_FFFF;
    write_burst(26'h20, 4'd1, 1, 4'hF, -1);
    wdat[0] = 32'h1234_5678;
    write_burst(26'h20, 4'd1, 1, 4'b0101, -1);
    rexp[0] = 32'hFF34_FF78;
    read_burst(26'h20, 4'd1, 1);

    // Size 0 is a single beat and leaves the FSM idle
    wdat[0] = 32'h11; wdat[1] = 32'h22;
    write_burst(26'h30, 4'd2, 2, 4'hF, -1);
    wdat[0] = 32'h99;
    write_burst(26'h30, 4'd0, 1, 4'hF, -1);
    rexp[0] = 32'h99; rexp[1] = 32'h22;
    read_burst(26'h30, 4'd2, 2);

    // Write gap stalls the beat counter
    wdat[0] = 32'h7; wdat[1] = 32'h8; wdat[2] = 32'h9;
    write_burst(26'h40, 4'd3, 3, 4'hF, 1);
    rexp[0] = 32'h7; rexp[1] = 32'h8; rexp[2] = 32'h9;
    read_burst(26'h40, 4'd3, 3);
    chk1("proto_clean", proto_err, 1'b0);

    // Align to the end of a refresh, then let the next one fall due mid-burst
    n = 0;
    while (local_ready === 1'b1 && n < 100) begin @(negedge ddr2_clk); n++; end
    if (n >= 100) chk1("ref_sync_drop", local_ready, 1'b0);
    n = 0;
    while (local_ready !== 1'b1 && n < 10) begin @(negedge ddr2_clk); n++; end
    if (n >= 10) chk1("ref_sync_rise", local_ready, 1'b1);
    repeat (60) @(negedge ddr2_clk);
    for (int i = 0; i < 8; i++) wdat[i] = 32'h100 + 32'(i);
    write_burst(26'h80, 4'd8, 8, 4'hF, -1);
    for (int k = 0; k < 4; k++) begin
      chk1("ref_stall", local_ready, 1'b0);
      @(negedge ddr2_clk);
    end
    chk1("ref_done", local_ready, 1'b1);
    for (int i = 0; i < 8; i++) rexp[i] = 32'h100 + 32'(i);
    read_burst(26'h80, 4'd8, 8);

    // Read and write together: write wins, error sticks
    wdat[0] = 32'h1111;
    write_burst(26'h60, 4'd1, 1, 4'hF, -1);
    wait_ready("both_wait");
    local_write_req  = 1'b1;
    local_read_req   = 1'b1;
    local_burstbegin = 1'b1;
    local_address    = 26'h50;
    local_size       = 4'd1;
    local_wdata      = 32'hCAFE;
    local_be         = 4'hF;
    @(negedge ddr2_clk);
    local_write_req  = 1'b0;
    local_read_req   = 1'b0;
    local_burstbegin = 1'b0;
    chk1("both_proto", proto_err, 1'b1);
    for (int k = 0; k < 6; k++) begin
      @(negedge ddr2_clk);
      chk1("both_no_read", local_rdata_valid, 1'b0);
    end
    rexp[0] = 32'hCAFE;
    read_burst(26'h50, 4'd1, 1);
    chk1("proto_sticky", proto_err, 1'b1);

    // Reset mid-burst keeps completed beats
    wait_ready("mid_wait");
    wdat[0] = 32'h5; wdat[1] = 32'h6;
    for (int i = 0; i < 2; i++) begin
      local_write_req  = 1'b1;
      local_burstbegin = (i == 0);
      local_address    = 26'h70;
      local_size       = 4'd4;
      local_wdata      = wdat[i];
      local_be         = 4'hF;
      @(negedge ddr2_clk);
    end
    local_write_req  = 1'b0;
    local_burstbegin = 1'b0;
    sys_rst_n = 1'b0;
    #1;
    chk1("async_ready", local_ready, 1'b0);
    chk1("async_init_done", local_init_done, 1'b0);
    chk1("async_proto", proto_err, 1'b0);
    repeat (2) @(negedge ddr2_clk);
    sys_rst_n = 1'b1;
    do_init();
    rexp[0] = 32'h5; rexp[1] = 32'h6;
    read_burst(26'h70, 4'd2, 2);
    rexp[0] = 32'h1;
    read_burst(26'h10, 4'd1, 1);

    // Request without burstbegin is ignored and flagged
    chk1("proto_after_rst", proto_err, 1'b0);
    wait_ready("nobb_wait");
    local_write_req = 1'b1;
    local_address   = 26'h60;
    local_size      = 4'd1;
    local_wdata     = 32'hBAD;
    local_be        = 4'hF;
    @(negedge ddr2_clk);
    local_write_req = 1'b0;
    chk1("nobb_proto", proto_err, 1'b1);
    rexp[0] = 32'h1111;
    read_burst(26'h60, 4'd1, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end

endmodule
